// File: rtl/sumofeven_inverse.sv
// sumofeven_inverse: finds the largest even term k (0..14) whose running
// even-sum 2+4+...+k does not exceed a captured target S. One term is added
// per clock. The result is reported with an exact-match flag and an
// out-of-range flag, behind a start/done handshake.
module sumofeven_inverse (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] S,
  output logic [3:0] N,
  output logic       exact,
  output logic       ovf,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] K_MAX   = 4'd14;
  localparam logic [6:0] SUM_MAX = 7'd56;

  logic [1:0] state;
  logic [6:0] s_reg;
  logic [6:0] acc;
  logic [3:0] k;

  logic [7:0] next_sum;
  logic       step;

  // Candidate sum if the next even term is added; 8 bits so 56+16 cannot wrap.
  function automatic logic [7:0] add_term(input logic [6:0] a, input logic [3:0] t);
    add_term = {1'b0, a} + {4'b0000, t} + 8'd2;
  endfunction

  // Decide whether another term still fits under the captured target.
  always_comb begin
    next_sum = add_term(acc, k);
    step     = (k < K_MAX) && (next_sum <= {1'b0, s_reg});
  end

  // Control FSM with the search registers and the held result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s_reg <= '0;
      acc   <= '0;
      k     <= '0;
      N     <= '0;
      exact <= 1'b0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            s_reg <= S;
            acc   <= '0;
            k     <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          if (step) begin
            acc <= next_sum[6:0];
            k   <= k + 4'd2;
          end else begin
            // Outputs change only here, so they stay stable through IDLE.
            N     <= k;
            exact <= (acc == s_reg);
            ovf   <= (s_reg > SUM_MAX);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
